// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, legality check and the command payload.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_OR  = 3'b111;

    typedef struct packed {
        logic [63:0] in1;
        logic [63:0] in2;
        logic [2:0]  op;
    } alu_cmd_t;

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_req_master_if.sv
// Host command, ALU request/result and host response channels of alu_req_master.
interface alu_req_master_if #(parameter int TAG_W = 4);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [63:0]      cmd_in1;
    logic [63:0]      cmd_in2;
    logic [2:0]       cmd_op;
    logic             flush;
    logic [63:0]      alu_in1;
    logic [63:0]      alu_in2;
    logic [2:0]       alu_op;
    logic             alu_in_valid;
    logic             alu_in_ready;
    logic [63:0]      alu_res;
    logic             alu_out_valid;
    logic             alu_out_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_res;
    logic [TAG_W-1:0] rsp_tag;
    logic [7:0]       err_cnt;
    logic             busy;

    modport master (
        input  cmd_valid, cmd_in1, cmd_in2, cmd_op, flush,
        input  alu_in_ready, alu_res, alu_out_valid, rsp_ready,
        output cmd_ready, alu_in1, alu_in2, alu_op, alu_in_valid,
        output alu_out_ready, rsp_valid, rsp_res, rsp_tag, err_cnt, busy
    );

    modport slave (
        output cmd_valid, cmd_in1, cmd_in2, cmd_op, flush,
        output alu_in_ready, alu_res, alu_out_valid, rsp_ready,
        input  cmd_ready, alu_in1, alu_in2, alu_op, alu_in_valid,
        input  alu_out_ready, rsp_valid, rsp_res, rsp_tag, err_cnt, busy
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, combinational head read and same-cycle flush.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_req_master.sv
// ALU initiator: queues host commands, issues them one at a time, tags results in order
// and returns them through a response register; illegal opcodes are dropped and counted.
module alu_req_master
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    alu_req_master_if.master bus
);

    alu_cmd_t         fifo_wdata;
    alu_cmd_t         fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             head_legal;
    logic             issue_hs;
    logic             res_hs;
    logic             out_ready;

    alu_cmd_t         iss_q;
    logic             iss_vld;
    logic [TAG_W-1:0] tag_cnt;
    logic [TAG_W-1:0] inflight_tag;
    logic             inflight;
    logic             rsp_vld;
    logic [63:0]      rsp_res_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic [7:0]       err_q;

    assign fifo_wdata    = '{in1: bus.cmd_in1, in2: bus.cmd_in2, op: bus.cmd_op};
    assign bus.cmd_ready = !fifo_full && !bus.flush;
    assign push          = bus.cmd_valid && bus.cmd_ready;

    sync_fifo #(.WIDTH($bits(alu_cmd_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (bus.flush),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A flush cycle pops nothing: every entry still queued at that edge is discarded.
    assign issue_hs   = iss_vld && bus.alu_in_ready;
    assign pop        = !fifo_empty && !bus.flush && (!iss_vld || issue_hs);
    assign head_legal = op_legal(fifo_rdata.op);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            iss_q   <= '0;
            iss_vld <= 1'b0;
        end else if (pop) begin
            iss_vld <= head_legal;
            if (head_legal) iss_q <= fifo_rdata;
        end else if (issue_hs) begin
            iss_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn)                                      err_q <= '0;
        else if (pop && !head_legal && err_q != 8'hFF)  err_q <= err_q + 8'd1;
    end

    // The ALU returns at most one result per issue, so one tag register tracks the in-flight op.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tag_cnt      <= '0;
            inflight_tag <= '0;
            inflight     <= 1'b0;
        end else if (issue_hs) begin
            inflight_tag <= tag_cnt;
            tag_cnt      <= tag_cnt + TAG_W'(1);
            inflight     <= 1'b1;
        end else if (res_hs) begin
            inflight     <= 1'b0;
        end
    end

    assign out_ready = !rsp_vld || bus.rsp_ready;
    assign res_hs    = bus.alu_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rsp_vld   <= 1'b0;
            rsp_res_q <= '0;
            rsp_tag_q <= '0;
        end else if (res_hs) begin
            rsp_vld   <= 1'b1;
            rsp_res_q <= bus.alu_res;
            rsp_tag_q <= inflight_tag;
        end else if (bus.rsp_ready) begin
            rsp_vld   <= 1'b0;
        end
    end

    assign bus.alu_in1       = iss_q.in1;
    assign bus.alu_in2       = iss_q.in2;
    assign bus.alu_op        = iss_q.op;
    assign bus.alu_in_valid  = iss_vld;
    assign bus.alu_out_ready = out_ready;
    assign bus.rsp_valid     = rsp_vld;
    assign bus.rsp_res       = rsp_res_q;
    assign bus.rsp_tag       = rsp_tag_q;
    assign bus.err_cnt       = err_q;
    assign bus.busy          = !fifo_empty || iss_vld || inflight || rsp_vld;

endmodule

// File: tb/tb_alu_req_master.sv
// Bench for alu_req_master: single-stage ALU model, scoreboard of expected {res, tag}.
module tb_alu_req_master;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    typedef struct {
        logic [63:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic alu_stall;
    logic alu_ov;
    logic [63:0] alu_r;

    exp_t sb[$];
    logic [TAG_W-1:0] exp_tag;
    int checks;
    int errors;
    int cyc;

    always #5 clk = ~clk;

    alu_req_master_if #(.TAG_W(TAG_W)) bus ();

    alu_req_master #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_XOR:  return a ^ b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return 64'd0;
        endcase
    endfunction

    // Registered ALU; it stops accepting while its result is stalled.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            alu_ov <= 1'b0;
            alu_r  <= '0;
        end else if (bus.alu_in_valid && bus.alu_in_ready) begin
            alu_ov <= 1'b1;
            alu_r  <= alu_f(bus.alu_in1, bus.alu_in2, bus.alu_op);
        end else if (bus.alu_out_ready) begin
            alu_ov <= 1'b0;
        end
    end

    assign bus.alu_out_valid = alu_ov;
    assign bus.alu_res       = alu_r;
    assign bus.alu_in_ready  = !alu_stall && (!alu_ov || bus.alu_out_ready);

    // Scores a response handshake due at the coming edge, then advances to the next negedge.
    task automatic tick();
        exp_t e;
        #1;
        if (rstn && bus.rsp_valid && bus.rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp got res=%0h tag=%0d expected no response", bus.rsp_res, bus.rsp_tag);
            end else begin
                e = sb.pop_front();
                if (bus.rsp_res !== e.res || bus.rsp_tag !== e.tag) begin
                    errors++;
                    $display("FAIL rsp got res=%0h tag=%0d expected res=%0h tag=%0d", bus.rsp_res, bus.rsp_tag, e.res, e.tag);
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                        input logic [63:0] exp_res, input bit track);
        int n;
        logic acc;
        bus.cmd_in1   = a;
        bus.cmd_in2   = b;
        bus.cmd_op    = op;
        bus.cmd_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            #1;
            acc = bus.cmd_ready;
            tick();
            n++;
        end
        bus.cmd_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got cmd_ready=0 for %0d cycles expected acceptance", n);
        end else if (track) begin
            sb.push_back('{exp_res, exp_tag});
            exp_tag++;
        end
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.rsp_valid) && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d responses missing expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_in1   = '0;
        bus.cmd_in2   = '0;
        bus.cmd_op    = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b1;
        alu_stall     = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        sb.delete();
        exp_tag = '0;
    endtask

    task automatic check_reset_values(input string tag);
        #1;
        checks += 10;
        if (bus.alu_in_valid !== 1'b0)  begin errors++; $display("FAIL %s_alu_in_valid got %b expected 0", tag, bus.alu_in_valid); end
        if (bus.alu_in1 !== 64'd0)      begin errors++; $display("FAIL %s_alu_in1 got %0h expected 0", tag, bus.alu_in1); end
        if (bus.alu_in2 !== 64'd0)      begin errors++; $display("FAIL %s_alu_in2 got %0h expected 0", tag, bus.alu_in2); end
        if (bus.alu_op !== 3'd0)        begin errors++; $display("FAIL %s_alu_op got %0d expected 0", tag, bus.alu_op); end
        if (bus.rsp_valid !== 1'b0)     begin errors++; $display("FAIL %s_rsp_valid got %b expected 0", tag, bus.rsp_valid); end
        if (bus.rsp_res !== 64'd0)      begin errors++; $display("FAIL %s_rsp_res got %0h expected 0", tag, bus.rsp_res); end
        if (bus.rsp_tag !== '0)         begin errors++; $display("FAIL %s_rsp_tag got %0d expected 0", tag, bus.rsp_tag); end
        if (bus.busy !== 1'b0)          begin errors++; $display("FAIL %s_busy got %b expected 0", tag, bus.busy); end
        if (bus.cmd_ready !== 1'b1)     begin errors++; $display("FAIL %s_cmd_ready got %b expected 1", tag, bus.cmd_ready); end
        if (bus.alu_out_ready !== 1'b1) begin errors++; $display("FAIL %s_alu_out_ready got %b expected 1", tag, bus.alu_out_ready); end
        checks++;
        if (bus.err_cnt !== 8'd0)       begin errors++; $display("FAIL %s_err_cnt got %0d expected 0", tag, bus.err_cnt); end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_values("reset");
    endtask

    task automatic test_single();
        do_reset();
        send(64'd5, 64'd7, OP_ADD, 64'd12, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.rsp_valid !== (k == 3)) begin
                errors++;
                $display("FAIL single_latency cycle+%0d got rsp_valid=%b expected %b", k, bus.rsp_valid, (k == 3));
            end
            tick();
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b expected 0", bus.busy); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL single_rsp got %0d missing expected 0", sb.size()); end
    endtask

    task automatic test_stream();
        int hs[$];
        do_reset();
        send(64'd10,   64'd3,    OP_SUB, 64'h7,  1'b1);
        send(64'hF0,   64'h0F,   OP_XOR, 64'hFF, 1'b1);
        send(64'hFF,   64'h0F,   OP_AND, 64'h0F, 1'b1);
        send(64'h0F,   64'hF0,   OP_OR,  64'hFF, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (bus.rsp_valid && bus.rsp_ready) hs.push_back(cyc);
            tick();
        end
        checks++;
        if (hs.size() != 4) begin
            errors++;
            $display("FAIL stream_count got %0d responses expected 4", hs.size());
        end else begin
            checks++;
            if (hs[3] - hs[0] != 3) begin
                errors++;
                $display("FAIL stream_rate got span %0d cycles expected 3", hs[3] - hs[0]);
            end
        end
        drain(5);
    endtask

    task automatic test_backpressure();
        logic [63:0] s_res, s_in1, s_in2;
        logic [TAG_W-1:0] s_tag;
        logic [2:0] s_op;
        do_reset();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 7; i++)
            send(64'd100 + 64'(i), 64'(i), OP_ADD, 64'd100 + 64'(2 * i), 1'b1);
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready got %b expected 0", bus.cmd_ready); end
        checks++;
        if (bus.rsp_res !== 64'd100 || bus.rsp_tag !== '0) begin
            errors++; $display("FAIL bp_rsp_head got res=%0h tag=%0d expected res=64 tag=0", bus.rsp_res, bus.rsp_tag);
        end
        checks++;
        if (bus.alu_in1 !== 64'd102 || bus.alu_in2 !== 64'd2) begin
            errors++; $display("FAIL bp_issue_head got in1=%0d in2=%0d expected in1=102 in2=2", bus.alu_in1, bus.alu_in2);
        end
        s_res = bus.rsp_res;
        s_tag = bus.rsp_tag;
        s_in1 = bus.alu_in1;
        s_in2 = bus.alu_in2;
        s_op  = bus.alu_op;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== s_res || bus.rsp_tag !== s_tag || bus.alu_out_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_rsp_hold got vld=%b res=%0h tag=%0d out_rdy=%b expected vld=1 res=%0h tag=%0d out_rdy=0",
                         bus.rsp_valid, bus.rsp_res, bus.rsp_tag, bus.alu_out_ready, s_res, s_tag);
            end
            checks++;
            if (bus.alu_in_valid !== 1'b1 || bus.alu_in1 !== s_in1 || bus.alu_in2 !== s_in2 || bus.alu_op !== s_op || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_issue_hold got vld=%b in1=%0h in2=%0h op=%0d cmd_rdy=%b expected vld=1 in1=%0h in2=%0h op=%0d cmd_rdy=0",
                         bus.alu_in_valid, bus.alu_in1, bus.alu_in2, bus.alu_op, bus.cmd_ready, s_in1, s_in2, s_op);
            end
        end
        bus.rsp_ready = 1'b1;
        drain(60);
    endtask

    task automatic test_illegal();
        do_reset();
        send(64'd0, 64'd0, 3'b011, 64'd0, 1'b0);
        send(64'd0, 64'd0, 3'b100, 64'd0, 1'b0);
        send(64'd1, 64'd1, OP_ADD, 64'd2, 1'b1);
        drain(20);
        checks++;
        if (bus.err_cnt !== 8'd2) begin errors++; $display("FAIL illegal_cnt got %0d expected 2", bus.err_cnt); end
        for (int i = 0; i < 300; i++) send(64'(i), 64'd1, 3'b101, 64'd0, 1'b0);
        tick();
        tick();
        tick();
        checks++;
        if (bus.err_cnt !== 8'd255) begin errors++; $display("FAIL illegal_sat got %0d expected 255", bus.err_cnt); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL illegal_busy got %b expected 0", bus.busy); end
        send(64'd2, 64'd3, OP_ADD, 64'd5, 1'b1);
        drain(20);
    endtask

    task automatic test_flush();
        do_reset();
        alu_stall = 1'b1;
        send(64'd1, 64'd2, OP_ADD, 64'd3, 1'b1);
        send(64'd20, 64'd1, OP_ADD, 64'd0, 1'b0);
        send(64'd30, 64'd1, OP_ADD, 64'd0, 1'b0);
        send(64'd40, 64'd1, OP_ADD, 64'd0, 1'b0);
        checks++;
        if (bus.alu_in_valid !== 1'b1 || bus.alu_in1 !== 64'd1) begin
            errors++; $display("FAIL flush_issue_pre got vld=%b in1=%0d expected vld=1 in1=1", bus.alu_in_valid, bus.alu_in1);
        end
        bus.flush     = 1'b1;
        bus.cmd_in1   = 64'd9;
        bus.cmd_in2   = 64'd9;
        bus.cmd_op    = OP_ADD;
        bus.cmd_valid = 1'b1;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL flush_cmd_ready got %b expected 0", bus.cmd_ready); end
        tick();
        bus.flush     = 1'b0;
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.alu_in_valid !== 1'b1 || bus.alu_in1 !== 64'd1) begin
            errors++; $display("FAIL flush_issue_post got vld=%b in1=%0d expected vld=1 in1=1", bus.alu_in_valid, bus.alu_in1);
        end
        alu_stall = 1'b0;
        drain(20);
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b expected 0", bus.busy); end
        send(64'd5, 64'd5, OP_ADD, 64'd10, 1'b1);
        drain(20);
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.rsp_ready = 1'b0;
        send(64'd3, 64'd4, OP_ADD, 64'd7, 1'b1);
        send(64'd1, 64'd1, OP_ADD, 64'd2, 1'b1);
        send(64'd2, 64'd2, OP_ADD, 64'd4, 1'b1);
        tick();
        tick();
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== 64'd7 || bus.alu_in_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_pre got rsp_vld=%b res=%0d in_vld=%b expected 1 7 1", bus.rsp_valid, bus.rsp_res, bus.alu_in_valid);
        end
        rstn = 1'b0;
        tick();
        check_reset_values("midrst");
        sb.delete();
        exp_tag       = '0;
        rstn          = 1'b1;
        bus.rsp_ready = 1'b1;
        send(64'd8, 64'd9, OP_ADD, 64'd17, 1'b1);
        drain(20);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        exp_tag       = '0;
        alu_stall     = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_in1   = '0;
        bus.cmd_in2   = '0;
        bus.cmd_op    = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_illegal();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
